pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register: the next generation of the fixed EX/MEM-style stage latch. It replaces the global stall wire with a per-stage valid/ready handshake, adds a two-entry skid buffer so `in_ready` is a pure register output that breaks the backward ready path, and keeps flush semantics. Upstream and downstream stage logic pack their control and data fields into one `DATA_W` bundle. The block sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) and also provides saturating stall and flush statistics for performance debug.

## Interface
Parameters:
- `DATA_W`, default 128: width of the packed stage bundle.
- `CNT_W`, default 16: width of each statistics counter.
- `CLEAR_ON_FLUSH`, default 1: when 1, data registers are zeroed on flush/reset. When 0, data registers hold their value and only valid state is cleared.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all held and incoming entries this cycle.
- `in_valid` in 1: upstream bundle valid.
- `in_ready` out 1: stage can accept; registered (derived only from state).
- `in_data` in `DATA_W`: upstream bundle.
- `out_valid` out 1: bundle available downstream.
- `out_ready` in 1: downstream accepts.
- `out_data` out `DATA_W`: bundle to downstream; driven from the main register only.
- `occupancy` out 2: number of held entries, 0..2.
- `stall_cnt` out `CNT_W`: cycles with `out_valid & ~out_ready`.
- `flush_cnt` out `CNT_W`: flush cycles that discarded at least one valid entry.

## Operation
- Storage consists of a main register `M`, which drives `out_data`, and a skid register `S`. State encoding: EMPTY (0 entries), BUSY (1 entry, in `M`), FULL (2 entries; `M` is older, `S` is newer).
- Outputs by state:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (state != FULL)`.
  - `occupancy`: EMPTY = 0, BUSY = 1, FULL = 2.
- Define `acc = in_valid & in_ready` and `rel = out_valid & out_ready`.
- Transitions when `flush = 0`:
  - EMPTY: if `acc`, then `M <= in_data` and go to BUSY.
  - BUSY:
    - `acc & rel`: `M <= in_data`, stay in BUSY.
    - `acc & ~rel`: `S <= in_data`, go to FULL.
    - `~acc & rel`: go to EMPTY.
    - Otherwise: hold.
  - FULL (`acc` is impossible): if `rel`, then `M <= S` and go to BUSY; otherwise hold.
- Priority is reset > flush > handshake.
- Flush behaviour:
  - Next state is EMPTY regardless of `in_valid` or `out_ready`.
  - An incoming bundle in the flush cycle is dropped. Upstream may see `acc = 1`, and that transfer is considered killed.
  - `out_valid` may be 1 in the flush cycle. If `out_ready` is also 1, the downstream transfer is legal and is not retracted. Flush only affects state from the next edge.
  - If `CLEAR_ON_FLUSH = 1`, then `M` and `S` are set to 0.
- Ordering: bundles leave in acceptance order. No bundle is duplicated or lost except by flush.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid & ~out_ready`, including a flush cycle.
  - Saturates at 2^`CNT_W` − 1.
  - Cleared only by reset.
- `flush_cnt`:
  - Increments when `flush & (state != EMPTY | in_valid)`.
  - Saturates at 2^`CNT_W` − 1.
  - Cleared only by reset.

## Timing
- Reset values, one edge after `reset` = 1:
  - state = EMPTY, so `out_valid = 0`, `in_ready = 1`, `occupancy = 0`.
  - `out_data = 0`, `S = 0` (regardless of `CLEAR_ON_FLUSH`).
  - `stall_cnt = 0`, `flush_cnt = 0`.
- All inputs are ignored while `reset` is high, including `flush`.
- Latency: a bundle accepted at edge N is on `out_data` with `out_valid = 1` after edge N, i.e. 1 cycle.
- Throughput: 1 bundle per cycle sustained when `out_ready` stays high.
- Ready timing:
  - `in_ready` falls one cycle after the first `out_ready = 0` cycle that coincides with an accept in BUSY. The skid register absorbs that accept.
  - `in_ready` rises one cycle after a release from FULL.
- No combinational path from `out_ready` to `in_ready`. No combinational path from `in_*` to `out_*`.
- `out_data` is stable while `out_valid & ~out_ready`.
- Reset asserted mid-operation discards both entries exactly as flush does, and additionally clears the counters.

## Test plan
- Reset then stream: hold `reset` = 1 for 2 cycles, then release. Check `in_ready = 1`, `out_valid = 0`, counters = 0. Feed bundles 0x1..0x8 back-to-back with `out_ready = 1`; each must appear exactly 1 cycle after accept, in order, with no bubbles.
- Backpressure/skid: in BUSY holding 0xA, drive 0xB with `out_ready = 0`. Required: FULL, `in_ready = 0` next cycle, `occupancy = 2`, `out_data` = 0xA held. Raise `out_ready`; 0xA then 0xB must emerge, and `in_ready` returns to 1 after the first release. `stall_cnt` must equal the number of held cycles.
- Flush in FULL with `in_valid = 1` (0xC): next cycle `out_valid = 0`, `occupancy = 0`, `out_data = 0` (`CLEAR_ON_FLUSH = 1`). 0xC must never appear. `flush_cnt` increments by 1.
- Flush with `CLEAR_ON_FLUSH = 0` while holding 0xD: `out_valid = 0` next cycle and `out_data` still 0xD. Flush while EMPTY with `in_valid = 0`: `flush_cnt` unchanged.
- Counter saturation with `CNT_W` = 4: hold `out_ready = 0` with a valid entry for 20 cycles. `stall_cnt` must stick at 15. A subsequent flush must not clear it; reset clears it to 0.
- Random regression: random `in_valid`, `out_ready`, and 5% `flush` over 10k cycles against a queue scoreboard. Check no loss or duplication except flushed entries, `occupancy` always in 0..2, and `in_ready = 0` only when `occupancy = 2`.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Pipeline-stage register with a valid/ready handshake on both sides and a
// two-entry skid buffer. in_ready depends only on registered state, which
// breaks the combinational backward ready path. Flush discards the held
// entries and any entry offered in the same cycle. Saturating statistics
// count stall cycles and flushes that discarded work.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; clears state, data and counters
//   flush      - discard held and incoming entries this cycle
//   in_valid   - upstream bundle valid
//   in_ready   - stage can accept (decoded from state only)
//   in_data    - upstream bundle, DATA_W bits
//   out_valid  - bundle available downstream
//   out_ready  - downstream accepts
//   out_data   - bundle to downstream, always from the main register
//   occupancy  - number of held entries, 0..2
//   stall_cnt  - saturating count of out_valid & ~out_ready cycles
//   flush_cnt  - saturating count of flushes that discarded a valid entry
module pipe_stage_skid #(
    parameter int DATA_W         = 128,
    parameter int CNT_W          = 16,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] main_p0;   // older entry, drives out_data
    logic [DATA_W-1:0] skid_p1;   // newer entry, only used in FULL

    logic acc;
    logic rel;
    logic load_main;
    logic main_from_skid;
    logic load_skid;
    logic stall_evt;
    logic flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign occupancy = state_q;
    assign out_data  = main_p0;

    assign acc = in_valid & in_ready;
    assign rel = out_valid & out_ready;

    assign stall_evt = out_valid & ~out_ready;
    assign flush_evt = flush & (out_valid | in_valid);

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        load_main = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && rel) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (rel) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- stage boundary: main / skid data registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            main_p0 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_p0 <= '0;
                skid_p1 <= '0;
            end
        end else begin
            if (load_main) begin
                main_p0 <= main_from_skid ? skid_p1 : in_data;
            end
            if (load_skid) begin
                skid_p1 <= in_data;
            end
        end
    end

    // ---- stage boundary: statistics counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_evt) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus a randomized
// regression against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: CLEAR_ON_FLUSH = 1, narrow counters
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    // DUT B: CLEAR_ON_FLUSH = 0
    logic          b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occupancy;
    logic [CW-1:0] b_stall_cnt, b_flush_cnt;

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of held bundles (capacity 2) plus counters.
    logic [DW-1:0] q[$];
    int  m_stall = 0;
    int  m_flush = 0;
    bit  armed   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("occ_range", 64'(occupancy <= 2'd2), 64'd1);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
    endtask

    // One clock cycle on DUT A: check current outputs, apply inputs,
    // advance the model by the handshake rules, then cross the edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
        bit ov, acc, rel;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        if (armed) check_model();
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            ov  = (q.size() > 0);
            acc = iv && (q.size() < 2);
            rel = ov && ordy;
            if (ov && !ordy && m_stall < SAT) m_stall++;
            if (fl) begin
                if ((ov || iv) && m_flush < SAT) m_flush++;
                q.delete();
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        if (rst) armed = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // DUT B: flush without clearing data
        repeat (2) @(posedge clk);
        #1;
        b_reset = 1'b0;
        chk("b_rst_in_ready",  64'(b_in_ready),  64'd1);
        chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_rst_out_data",  64'(b_out_data),  64'd0);
        b_in_valid = 1'b1; b_in_data = 32'hD;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("b_hold_valid", 64'(b_out_valid), 64'd1);
        chk("b_hold_data",  64'(b_out_data),  64'hD);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        chk("b_flush_valid", 64'(b_out_valid), 64'd0);
        chk("b_flush_data",  64'(b_out_data),  64'hD);
        chk("b_flush_cnt",   64'(b_flush_cnt), 64'd1);
        chk("b_stall_cnt",   64'(b_stall_cnt), 64'd1);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        chk("b_idle_flush_cnt", 64'(b_flush_cnt), 64'd1);
        chk("b_idle_occ",       64'(b_occupancy), 64'd0);

        // DUT A: reset for two cycles
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hFF, 1'b1, 1'b1, 1'b1);
        check_model();
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Back-to-back stream with out_ready high
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid register
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("skid_occ",  64'(occupancy), 64'd2);
        chk("skid_data", 64'(out_data),  64'hA);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with an incoming bundle
        step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        check_model();
        chk("flush_clear_data", 64'(out_data), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_no_c", 64'(out_valid), 64'd0);

        // Stall counter saturation, survives flush, cleared by reset
        step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(SAT));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("stall_after_flush", 64'(stall_cnt), 64'(SAT));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stall_after_reset", 64'(stall_cnt), 64'd0);

        // Random regression
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)),
                 ($urandom_range(99) < 5), (i == 5000));
            if (in_ready == 1'b0) chk("rdy_low_full", 64'(occupancy), 64'd2);
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
